// File: rtl/tictactoe_game.sv
// N x N tic-tac-toe engine: registered board, X-first turn tracking, move validation
// and a one-cycle win/draw evaluation after each accepted move.
module tictactoe_game #(
    parameter int N = 3,
    localparam int IDXW = $clog2(N*N),
    localparam int CNTW = $clog2(N*N+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_game,
    input  logic              move_valid,
    input  logic [IDXW-1:0]   move_idx,
    output logic              move_ready,
    output logic              move_err,
    output logic [N*N-1:0]    board_x,
    output logic [N*N-1:0]    board_o,
    output logic              turn_o,
    output logic [CNTW-1:0]   move_count,
    output logic              win_x,
    output logic              win_o,
    output logic              draw,
    output logic              game_over
);

    localparam int CELLS = N * N;

    // Handshake: a move is taken on a rising edge where move_valid && move_ready;
    // the source holds move_valid/move_idx until then. Requests while not ready are
    // ignored in CHECK and answered with a move_err pulse in OVER.
    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t state;

    logic in_range;
    logic occupied;
    logic legal;
    logic line_x;
    logic line_o;

    function automatic logic has_line(input logic [CELLS-1:0] b);
        logic found;
        logic row_ok;
        logic col_ok;
        logic diag_ok;
        logic anti_ok;
        found   = 1'b0;
        diag_ok = 1'b1;
        anti_ok = 1'b1;
        for (int r = 0; r < N; r++) begin
            row_ok = 1'b1;
            col_ok = 1'b1;
            for (int c = 0; c < N; c++) begin
                row_ok = row_ok & b[r*N + c];
                col_ok = col_ok & b[c*N + r];
            end
            found   = found | row_ok | col_ok;
            diag_ok = diag_ok & b[r*N + r];
            anti_ok = anti_ok & b[r*N + (N-1-r)];
        end
        return found | diag_ok | anti_ok;
    endfunction

    always_comb begin
        in_range = (int'(move_idx) < CELLS);
        occupied = 1'b0;
        if (in_range) begin
            occupied = board_x[move_idx] | board_o[move_idx];
        end
        legal  = in_range & ~occupied;
        line_x = has_line(board_x);
        line_o = has_line(board_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PLAY;
            move_ready <= 1'b1;
            move_err   <= 1'b0;
            board_x    <= '0;
            board_o    <= '0;
            turn_o     <= 1'b0;
            move_count <= '0;
            win_x      <= 1'b0;
            win_o      <= 1'b0;
            draw       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            move_err <= 1'b0;
            if (new_game) begin
                state      <= PLAY;
                move_ready <= 1'b1;
                board_x    <= '0;
                board_o    <= '0;
                turn_o     <= 1'b0;
                move_count <= '0;
                win_x      <= 1'b0;
                win_o      <= 1'b0;
                draw       <= 1'b0;
                game_over  <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (move_valid) begin
                            if (legal) begin
                                if (turn_o) begin
                                    board_o[move_idx] <= 1'b1;
                                end else begin
                                    board_x[move_idx] <= 1'b1;
                                end
                                move_count <= move_count + CNTW'(1);
                                turn_o     <= ~turn_o;
                                move_ready <= 1'b0;
                                state      <= CHECK;
                            end else begin
                                move_err <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        // Only the mover can complete a line, so at most one win flag rises.
                        win_x <= line_x;
                        win_o <= line_o;
                        draw  <= (move_count == CNTW'(CELLS)) & ~line_x & ~line_o;
                        if (line_x | line_o | (move_count == CNTW'(CELLS))) begin
                            game_over  <= 1'b1;
                            move_ready <= 1'b0;
                            state      <= OVER;
                        end else begin
                            move_ready <= 1'b1;
                            state      <= PLAY;
                        end
                    end
                    OVER: begin
                        if (move_valid) begin
                            move_err <= 1'b1;
                        end
                    end
                    default: begin
                        move_ready <= 1'b1;
                        state      <= PLAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tictactoe_game.sv
// Directed bench for tictactoe_game: one 3x3 and one 4x4 engine, expectations queued
// as stimulus is driven and popped when the outputs are sampled.
module tb_tictactoe_game;

    logic clk = 1'b0;
    logic rst;

    logic        ng3, mv3;
    logic [3:0]  idx3;
    logic        ready3, err3, turn3, wx3, wo3, dr3, go3;
    logic [8:0]  bx3, bo3;
    logic [3:0]  cnt3;

    logic        ng4, mv4;
    logic [3:0]  idx4;
    logic        ready4, err4, turn4, wx4, wo4, dr4, go4;
    logic [15:0] bx4, bo4;
    logic [4:0]  cnt4;

    logic [31:0] exp_q[$];
    int n_asserts = 0;
    int n_fail    = 0;

    tictactoe_game #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .new_game(ng3), .move_valid(mv3), .move_idx(idx3),
        .move_ready(ready3), .move_err(err3), .board_x(bx3), .board_o(bo3),
        .turn_o(turn3), .move_count(cnt3), .win_x(wx3), .win_o(wo3), .draw(dr3),
        .game_over(go3)
    );

    tictactoe_game #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .new_game(ng4), .move_valid(mv4), .move_idx(idx4),
        .move_ready(ready4), .move_err(err4), .board_x(bx4), .board_o(bo4),
        .turn_o(turn4), .move_count(cnt4), .win_x(wx4), .win_o(wo4), .draw(dr4),
        .game_over(go4)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            compare({tag, "_noexp"}, obs, ~obs);
        end else begin
            compare(tag, obs, exp_q.pop_front());
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        compare("disjoint3", 32'(bx3 & bo3), 32'd0);
        compare("disjoint4", 32'(bx4 & bo4), 32'd0);
    endtask

    task automatic play3(input int idx);
        idx3 = 4'(idx);
        mv3  = 1'b1;
        cyc();
        mv3  = 1'b0;
        cyc();
    endtask

    task automatic play4(input int idx);
        idx4 = 4'(idx);
        mv4  = 1'b1;
        cyc();
        mv4  = 1'b0;
        cyc();
    endtask

    task automatic new3();
        ng3 = 1'b1;
        cyc();
        ng3 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ng3 = 1'b0; mv3 = 1'b0; idx3 = '0;
        ng4 = 1'b0; mv4 = 1'b0; idx4 = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Reset state
        expect_v(1); expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0);
        check("rst_ready", 32'(ready3));
        check("rst_bx", 32'(bx3));
        check("rst_bo", 32'(bo3));
        check("rst_cnt", 32'(cnt3));
        check("rst_turn", 32'(turn3));
        check("rst_go", 32'(go3));
        check("rst_err", 32'(err3));

        // X wins the top row: X0 O3 X1 O4 X2
        idx3 = 4'd0; mv3 = 1'b1;
        expect_v(0); expect_v(1); expect_v(1); expect_v(1);
        cyc();
        mv3 = 1'b0;
        check("t1_ready_check", 32'(ready3));
        check("t1_bx_first", 32'(bx3));
        check("t1_turn_first", 32'(turn3));
        check("t1_cnt_first", 32'(cnt3));
        expect_v(1); expect_v(0);
        cyc();
        check("t1_ready_back", 32'(ready3));
        check("t1_go_early", 32'(go3));
        play3(3); play3(1); play3(4); play3(2);
        expect_v(1); expect_v(0); expect_v(1); expect_v(0); expect_v(5); expect_v(9'h007); expect_v(9'h018); expect_v(0);
        check("t1_win_x", 32'(wx3));
        check("t1_win_o", 32'(wo3));
        check("t1_go", 32'(go3));
        check("t1_ready", 32'(ready3));
        check("t1_cnt", 32'(cnt3));
        check("t1_bx", 32'(bx3));
        check("t1_bo", 32'(bo3));
        check("t1_draw", 32'(dr3));

        // Occupied and out-of-range requests
        new3();
        play3(4);
        idx3 = 4'd4; mv3 = 1'b1;
        expect_v(1); expect_v(0); expect_v(1); expect_v(1);
        cyc();
        mv3 = 1'b0;
        check("t2_err_occ", 32'(err3));
        check("t2_bo", 32'(bo3));
        check("t2_turn", 32'(turn3));
        check("t2_cnt", 32'(cnt3));
        expect_v(0);
        cyc();
        check("t2_err_pulse", 32'(err3));
        idx3 = 4'd9; mv3 = 1'b1;
        expect_v(1); expect_v(1);
        cyc();
        mv3 = 1'b0;
        check("t2_err_range", 32'(err3));
        check("t2_cnt_range", 32'(cnt3));

        // Draw: X0 O1 X2 O4 X3 O5 X7 O6 X8
        new3();
        play3(0); play3(1); play3(2); play3(4); play3(3);
        play3(5); play3(7); play3(6); play3(8);
        expect_v(9); expect_v(1); expect_v(0); expect_v(0); expect_v(1); expect_v(9'h18D); expect_v(9'h072);
        check("t3_cnt", 32'(cnt3));
        check("t3_draw", 32'(dr3));
        check("t3_win_x", 32'(wx3));
        check("t3_win_o", 32'(wo3));
        check("t3_go", 32'(go3));
        check("t3_bx", 32'(bx3));
        check("t3_bo", 32'(bo3));
        idx3 = 4'd0; mv3 = 1'b1;
        expect_v(1); expect_v(9);
        cyc();
        mv3 = 1'b0;
        check("t3_err_over", 32'(err3));
        check("t3_cnt_over", 32'(cnt3));

        // Ninth move completes the X diagonal: X0 O1 X2 O5 X3 O6 X4 O7 X8
        new3();
        play3(0); play3(1); play3(2); play3(5); play3(3);
        play3(6); play3(4); play3(7); play3(8);
        expect_v(9); expect_v(1); expect_v(0); expect_v(1);
        check("t4_cnt", 32'(cnt3));
        check("t4_win_x", 32'(wx3));
        check("t4_draw", 32'(dr3));
        check("t4_go", 32'(go3));

        // 4x4: O wins on the anti-diagonal 3,6,9,12
        play4(0); play4(3); play4(1); play4(6);
        play4(2); play4(9); play4(4); play4(12);
        expect_v(1); expect_v(0); expect_v(1); expect_v(8); expect_v(16'h1248); expect_v(16'h0017); expect_v(0);
        check("t5_win_o", 32'(wo4));
        check("t5_win_x", 32'(wx4));
        check("t5_go", 32'(go4));
        check("t5_cnt", 32'(cnt4));
        check("t5_bo", 32'(bo4));
        check("t5_bx", 32'(bx4));
        check("t5_ready", 32'(ready4));
        ng4 = 1'b1; mv4 = 1'b1; idx4 = 4'd5;
        expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(1); expect_v(0); expect_v(0); expect_v(0);
        cyc();
        ng4 = 1'b0; mv4 = 1'b0;
        check("t5_ng_bx", 32'(bx4));
        check("t5_ng_bo", 32'(bo4));
        check("t5_ng_cnt", 32'(cnt4));
        check("t5_ng_win_o", 32'(wo4));
        check("t5_ng_ready", 32'(ready4));
        check("t5_ng_turn", 32'(turn4));
        check("t5_ng_err", 32'(err4));
        check("t5_ng_go", 32'(go4));
        expect_v(0); expect_v(0);
        cyc();
        check("t5_ng_err_late", 32'(err4));
        check("t5_ng_bx_late", 32'(bx4));

        // Asynchronous reset while in CHECK
        new3();
        idx3 = 4'd0; mv3 = 1'b1;
        expect_v(1);
        cyc();
        mv3 = 1'b0;
        check("t6_bx_pre", 32'(bx3));
        rst = 1'b1;
        expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(1); expect_v(0);
        #1;
        check("t6_rst_bx", 32'(bx3));
        check("t6_rst_bo", 32'(bo3));
        check("t6_rst_cnt", 32'(cnt3));
        check("t6_rst_turn", 32'(turn3));
        check("t6_rst_ready", 32'(ready3));
        check("t6_rst_flags", 32'({wx3, wo3, dr3, go3}));
        cyc();
        rst = 1'b0;
        cyc();

        // A request held into CHECK is ignored silently
        idx3 = 4'd0; mv3 = 1'b1;
        cyc();
        idx3 = 4'd1;
        expect_v(1); expect_v(0); expect_v(1); expect_v(1); expect_v(1);
        cyc();
        mv3 = 1'b0;
        check("t6_chk_bx", 32'(bx3));
        check("t6_chk_err", 32'(err3));
        check("t6_chk_cnt", 32'(cnt3));
        check("t6_chk_ready", 32'(ready3));
        check("t6_chk_turn", 32'(turn3));
        expect_v(0); expect_v(1);
        cyc();
        check("t6_chk_err_late", 32'(err3));
        check("t6_chk_bx_late", 32'(bx3));

        compare("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
